fifo_occupancy_counter_bank: RTL and testbench

Bank of NUM_CH independent up/down occupancy counters with a shared programmable threshold. Each counter counts writes (inc) and reads (dec), saturates at the threshold and at zero, and reports per-channel done/empty status, a one-cycle done pulse, and sticky overflow/underflow errors. It is the multi-channel, bidirectional, programmable-target successor of the fixed 64-entry write counter. It sits beside the per-channel packet buffers and flags when each buffer has reached its target fill level.

---
 rtl/fifo_occupancy_counter_bank.sv | 124 ++++++++++++
 tb/tb_fifo_occupancy_counter_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_occupancy_counter_bank.sv
// fifo_occupancy_counter_bank
//   Bank of NUM_CH independent saturating up/down occupancy counters sharing a
//   programmable threshold. Each channel reports done (count >= target),
//   empty (count == 0), a one-cycle done pulse, and sticky overflow/underflow
//   errors for refused increments/decrements.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   flush/inc/dec     : [NUM_CH] per-channel clear / write / read requests
//   target_load       : load target_in (0 is stored as 1) into shared threshold
//   target_in         : [CNT_W] new threshold
//   err_clr           : clear all sticky error flags (new events win)
//   count_out         : [NUM_CH*CNT_W] channel i at [i*CNT_W +: CNT_W]
//   target            : [CNT_W] current threshold
//   done/empty        : [NUM_CH] status, combinational from registered state
//   done_pulse        : [NUM_CH] high in the first cycle done rises
//   ovf_err/unf_err   : [NUM_CH] sticky refused-inc / refused-dec flags

module fifo_occupancy_ch #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  input  logic             err_clr,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             empty,
  output logic             done_pulse,
  output logic             ovf_err,
  output logic             unf_err
);
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_set, unf_set, done_q;

  // target >= 1 and count < target before +1, so the increment never carries.
  always_comb begin
    cnt_nxt = count;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (flush) begin
      cnt_nxt = '0;
    end else if (inc && dec) begin
      cnt_nxt = count;
    end else if (inc) begin
      if (count < target) cnt_nxt = count + 1'b1;
      else                ovf_set = 1'b1;
    end else if (dec) begin
      if (count != '0) cnt_nxt = count - 1'b1;
      else             unf_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      done_q  <= 1'b0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      count   <= cnt_nxt;
      done_q  <= done;
      // set-dominant: an error in the clear cycle survives
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      unf_err <= unf_set | (unf_err & ~err_clr);
    end
  end

  assign done       = (count >= target);
  assign empty      = (count == '0);
  assign done_pulse = done & ~done_q;
endmodule

module fifo_occupancy_counter_bank #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 7,
  parameter int DEFAULT_TARGET = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       flush,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       dec,
  input  logic                    target_load,
  input  logic [CNT_W-1:0]        target_in,
  input  logic                    err_clr,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [CNT_W-1:0]        target,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       done_pulse,
  output logic [NUM_CH-1:0]       ovf_err,
  output logic [NUM_CH-1:0]       unf_err
);
  localparam logic [CNT_W-1:0] TGT_RST = CNT_W'(DEFAULT_TARGET);

  // Channels see the registered target, so inc in a load cycle is judged
  // against the old threshold. A zero target would make every channel
  // permanently done at empty, so it is clamped to 1.
  always_ff @(posedge clk) begin
    if (rst)              target <= TGT_RST;
    else if (target_load) target <= (target_in == '0) ? CNT_W'(1) : target_in;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fifo_occupancy_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush[g]),
      .inc        (inc[g]),
      .dec        (dec[g]),
      .err_clr    (err_clr),
      .target     (target),
      .count      (count_out[g*CNT_W +: CNT_W]),
      .done       (done[g]),
      .empty      (empty[g]),
      .done_pulse (done_pulse[g]),
      .ovf_err    (ovf_err[g]),
      .unf_err    (unf_err[g])
    );
  end
endmodule

// File: tb/tb_fifo_occupancy_counter_bank.sv
module tb_fifo_occupancy_counter_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 7;
  localparam int DEF_T  = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       flush, inc, dec;
  logic                    target_load, err_clr;
  logic [CNT_W-1:0]        target_in;
  logic [NUM_CH*CNT_W-1:0] count_out;
  logic [CNT_W-1:0]        target;
  logic [NUM_CH-1:0]       done, empty, done_pulse, ovf_err, unf_err;

  fifo_occupancy_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_TARGET(DEF_T)) dut (
    .clk(clk), .rst(rst), .flush(flush), .inc(inc), .dec(dec),
    .target_load(target_load), .target_in(target_in), .err_clr(err_clr),
    .count_out(count_out), .target(target), .done(done), .empty(empty),
    .done_pulse(done_pulse), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference state, plain integers
  int m_cnt [NUM_CH];
  int m_tgt;
  bit m_ovf [NUM_CH];
  bit m_unf [NUM_CH];
  bit m_prev_done [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_cnt(input int i);
    logic [CNT_W-1:0] v;
    v = count_out[i*CNT_W +: CNT_W];
    return int'(v);
  endfunction

  function automatic bit m_done(input int i);
    return m_cnt[i] >= m_tgt;
  endfunction

  // advance reference by one clock using the currently driven inputs
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_prev_done[i] = 0;
      end
      m_tgt = DEF_T;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        bit eo, eu;
        eo = 0; eu = 0;
        m_prev_done[i] = m_done(i);
        if (flush[i])               m_cnt[i] = 0;
        else if (inc[i] && dec[i])  ;
        else if (inc[i])            begin if (m_cnt[i] < m_tgt) m_cnt[i]++; else eo = 1; end
        else if (dec[i])            begin if (m_cnt[i] > 0) m_cnt[i]--; else eu = 1; end
        m_ovf[i] = eo || (m_ovf[i] && !err_clr);
        m_unf[i] = eu || (m_unf[i] && !err_clr);
      end
      if (target_load) m_tgt = (target_in == 0) ? 1 : int'(target_in);
    end
  endtask

  task automatic check_all();
    chk("target", 32'(target), 32'(m_tgt));
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("count%0d", i), 32'(dut_cnt(i)), 32'(m_cnt[i]));
      chk($sformatf("done%0d", i),  32'(done[i]),  32'(m_done(i)));
      chk($sformatf("empty%0d", i), 32'(empty[i]), 32'(m_cnt[i] == 0));
      chk($sformatf("pulse%0d", i), 32'(done_pulse[i]), 32'(m_done(i) && !m_prev_done[i]));
      chk($sformatf("ovf%0d", i),   32'(ovf_err[i]), 32'(m_ovf[i]));
      chk($sformatf("unf%0d", i),   32'(unf_err[i]), 32'(m_unf[i]));
    end
  endtask

  task automatic idle();
    rst = 0; flush = '0; inc = '0; dec = '0;
    target_load = 0; target_in = '0; err_clr = 0;
  endtask

  // one clock: model, edge, sample #1 after the edge, return inputs to idle
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    chk("rst_empty", 32'(empty), 32'(4'hF));
    chk("rst_target", 32'(target), 32'(DEF_T));

    // 64 writes to channel 0 reach the default target
    for (int k = 0; k < 64; k++) begin inc = 4'b0001; cyc(); end
    chk("c0_64", 32'(dut_cnt(0)), 32'd64);
    chk("c0_pulse", 32'(done_pulse[0]), 32'd1);
    inc = 4'b0001; cyc();
    chk("c0_hold", 32'(dut_cnt(0)), 32'd64);
    chk("c0_ovf", 32'(ovf_err[0]), 32'd1);
    chk("c0_pulse_once", 32'(done_pulse[0]), 32'd0);

    // underflow on channel 1, simultaneous inc&dec, then clear
    dec = 4'b0010; cyc();
    chk("c1_unf", 32'(unf_err[1]), 32'd1);
    for (int k = 0; k < 3; k++) begin inc = 4'b0010; dec = 4'b0010; cyc(); end
    chk("c1_zero", 32'(dut_cnt(1)), 32'd0);
    err_clr = 1; cyc();
    chk("c1_clr", 32'(unf_err[1]), 32'd0);

    // channel 2 to 10, load target 8 in same cycle as inc
    for (int k = 0; k < 10; k++) begin inc = 4'b0100; cyc(); end
    inc = 4'b0100; target_load = 1; target_in = 7'd8; cyc();
    chk("c2_11", 32'(dut_cnt(2)), 32'd11);
    chk("tgt8", 32'(target), 32'd8);
    chk("c2_pulse", 32'(done_pulse[2]), 32'd1);
    inc = 4'b0100; cyc();
    chk("c2_ovf", 32'(ovf_err[2]), 32'd1);
    chk("c2_held", 32'(dut_cnt(2)), 32'd11);

    // zero target clamps to 1
    target_load = 1; target_in = 7'd0; cyc();
    chk("tgt1", 32'(target), 32'd1);
    inc = 4'b1000; cyc();
    chk("c3_done", 32'(done[3]), 32'd1);
    inc = 4'b1000; cyc();
    chk("c3_ovf", 32'(ovf_err[3]), 32'd1);

    // channel 0 to 40 then flush wins over inc
    target_load = 1; target_in = 7'd64; flush = 4'b0001; cyc();
    for (int k = 0; k < 40; k++) begin inc = 4'b0001; cyc(); end
    err_clr = 1; cyc();
    inc = 4'b0001; flush = 4'b0001; cyc();
    chk("c0_flush", 32'(dut_cnt(0)), 32'd0);
    chk("c0_flush_noerr", 32'(ovf_err[0]), 32'd0);

    // reset mid-count overrides inc
    for (int k = 0; k < 5; k++) begin inc = 4'b1111; cyc(); end
    rst = 1; inc = 4'b1111; cyc();
    chk("rst2_cnt", 32'(count_out), 32'd0);
    chk("rst2_tgt", 32'(target), 32'(DEF_T));

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      inc   = 4'($urandom);
      dec   = 4'($urandom) & 4'($urandom);
      flush = ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'b0;
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 40) == 0) begin
        target_load = 1;
        target_in = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      end
      rst = ($urandom_range(0, 500) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
